// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: control-word layout, bubble encoding and the
// primary opcodes that the control decoder and the pipeline registers agree on.
package mips_pkg;

  localparam int CTRL_W = 9;

  // Bit positions inside the EXE_MEM_WB control word.
  localparam int CTRL_REGDST   = 8;
  localparam int CTRL_ALUOP_HI = 7;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEMREAD  = 3;
  localparam int CTRL_MEMWRITE = 2;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 0;

  localparam logic [CTRL_W-1:0] CTRL_BUBBLE = '0;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: compares the load sitting in EX against the
// source registers of the instruction in ID. Purely combinational.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid_i,
  input  logic                  ex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic                  id_valid_i,
  input  logic                  id_regdst_i,
  input  logic                  id_mem_write_i,
  input  logic                  id_branch_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  output logic                  hazard_o
);

  logic src_rt;
  logic rs_match;
  logic rt_match;

  // rt is a read operand for R-type, stores and branches; for I-type ALU ops
  // and loads it is the destination, so matching it would be a false stall.
  assign src_rt   = id_regdst_i | id_mem_write_i | id_branch_i;
  assign rs_match = (ex_rt_i == id_rs_i);
  assign rt_match = src_rt & (ex_rt_i == id_rt_i);

  // $zero never carries a real dependency.
  assign hazard_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0) &
                    id_valid_i & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall and bubble insertion.
// Optional saturating stall counter enabled by defining IDEX_STALL_CNT_EN.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = mips_pkg::CTRL_W,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CTRL_W-1:0]     inControl,
  input  logic                  inValid,
  input  logic                  inFlush,
  input  logic [DATA_W-1:0]     inPC,
  input  logic [DATA_W-1:0]     inRegA,
  input  logic [DATA_W-1:0]     inRegB,
  input  logic [DATA_W-1:0]     inImm,
  input  logic [REG_ADDR_W-1:0] inRs,
  input  logic [REG_ADDR_W-1:0] inRt,
  input  logic [REG_ADDR_W-1:0] inRd,
  output logic                  outStall,
  output logic [CTRL_W-1:0]     outControl,
  output logic                  outValid,
  output logic [DATA_W-1:0]     outPC,
  output logic [DATA_W-1:0]     outRegA,
  output logic [DATA_W-1:0]     outRegB,
  output logic [DATA_W-1:0]     outImm,
  output logic [REG_ADDR_W-1:0] outRs,
  output logic [REG_ADDR_W-1:0] outRt,
  output logic [REG_ADDR_W-1:0] outRd
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]      outStallCount
`endif
);

  logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
  logic                  valid_q, valid_d;
  logic                  capture;
  logic                  hazard;
  logic [DATA_W-1:0]     pc_q, rega_q, regb_q, imm_q;
  logic [REG_ADDR_W-1:0] rs_q, rt_q, rd_q;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard_detect (
    .ex_valid_i     (valid_q),
    .ex_mem_read_i  (ctrl_q[CTRL_MEMREAD]),
    .ex_rt_i        (rt_q),
    .id_valid_i     (inValid),
    .id_regdst_i    (inControl[CTRL_REGDST]),
    .id_mem_write_i (inControl[CTRL_MEMWRITE]),
    .id_branch_i    (inControl[CTRL_BRANCH]),
    .id_rs_i        (inRs),
    .id_rt_i        (inRt),
    .hazard_o       (hazard)
  );

  // A flush already squashes the ID instruction, so there is nothing to hold.
  assign outStall = hazard & ~inFlush;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    ctrl_d  = CTRL_BUBBLE;
    valid_d = 1'b0;
    capture = 1'b0;
    if (!inFlush && !hazard && inValid) begin
      ctrl_d  = inControl;
      valid_d = 1'b1;
      capture = 1'b1;
    end
  end

  // Bubbles only touch control and valid; data fields hold to avoid toggling.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the reset state of every field is visible on the outputs, so the
    // data registers are reset too rather than left uninitialised.
    if (!rst) begin
      ctrl_q  <= CTRL_BUBBLE;
      valid_q <= 1'b0;
      pc_q    <= '0;
      rega_q  <= '0;
      regb_q  <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      if (capture) begin
        pc_q   <= inPC;
        rega_q <= inRegA;
        regb_q <= inRegB;
        imm_q  <= inImm;
        rs_q   <= inRs;
        rt_q   <= inRt;
        rd_q   <= inRd;
      end
    end
  end

  assign outControl = ctrl_q;
  assign outValid   = valid_q;
  assign outPC      = pc_q;
  assign outRegA    = rega_q;
  assign outRegB    = regb_q;
  assign outImm     = imm_q;
  assign outRs      = rs_q;
  assign outRt      = rt_q;
  assign outRd      = rd_q;

`ifdef IDEX_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counts hazard bubbles only; saturates instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (outStall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign outStallCount = stall_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, directly downstream of the opcode control decoder.
- Captures the decoder's 9-bit EXE_MEM_WB control word and the operands of the instruction in decode.
- Detects load-use hazards and asserts a stall; inserts a bubble into EX on stall or branch flush.
- Feeds the EX stage (ALU, forwarding unit) and the EX/MEM register.

Parameters:
- DATA_W, 32, width of PC, register operands and sign-extended immediate.
- REG_ADDR_W, 5, register specifier width.
- CTRL_W, 9, control word width; layout fixed as [8]RegDst [7:6]ALUOp [5]ALUSrc [4]Branch [3]MemRead [2]MemWrite [1]RegWrite [0]MemtoReg.
- CNT_W, 32, stall counter width; used only with the optional feature.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- inControl  in  CTRL_W  control word from the decoder for the instruction in ID.
- inValid  in  1  the ID slot holds a real instruction.
- inFlush  in  1  taken branch resolved; squash the ID instruction.
- inPC  in  DATA_W  PC+4 of the ID instruction.
- inRegA / inRegB  in  DATA_W  register-file read data (rs, rt).
- inImm  in  DATA_W  sign-extended immediate.
- inRs / inRt / inRd  in  REG_ADDR_W  register specifiers.
- outStall  out  1  combinational; freezes PC and IF/ID this cycle.
- outControl  out  CTRL_W  registered control word for EX.
- outValid  out  1  registered; EX slot holds a real instruction.
- outPC, outRegA, outRegB, outImm  out  DATA_W  registered operands.
- outRs, outRt, outRd  out  REG_ADDR_W  registered specifiers.
- outStallCount  out  CNT_W  present only when the optional feature is compiled in.

Behaviour:
- Reset (rst=0, asynchronous): every registered output is 0, including outValid and outControl. outStall is 0 while in reset.
- Rt-is-source decode from inControl: srcRt = RegDst | MemWrite | Branch.
- Load-use hazard, evaluated combinationally: hazard = outValid & outControl[3] & (outRt != 0) & inValid & ((outRt == inRs) | (srcRt & (outRt == inRt))).
- outStall = hazard & ~inFlush.
- Each rising edge, priority order:
  - inFlush=1: load a bubble.
  - else hazard=1: load a bubble.
  - else: capture all inputs; outValid <= inValid.
- Bubble: outControl = 0 and outValid = 0. Data and specifier fields are don't-care and are held at their previous values (no toggling).
- Don't-care (X) bits in inControl are registered unchanged; downstream qualifies them by the Branch/MemWrite bits. A bubble is all zeros.
- Invalid input (inValid=0): captured as a bubble; outControl is forced to 0.
- Latency: exactly 1 cycle from inputs to outputs. No internal buffering.
- A stall lasts exactly one cycle by construction: the EX slot holds a bubble afterwards, so the hazard cannot persist.
- Back-to-back loads with a dependency chain stall once per dependent pair.
- Reset asserted mid-stall clears all state. outStall drops together with the reset assertion.

Optional Feature:
- Macro: IDEX_STALL_CNT_EN.
- Compiled in:
  - outStallCount increments by 1 on each edge where a hazard bubble is inserted.
  - A flush bubble does not count; flush and hazard in the same cycle does not count.
  - Saturates at all-ones and never wraps.
  - Reset value is 0.
- Compiled out: the port and the counter do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - CTRL_W and the control bit-index constants (CTRL_REGDST=8, CTRL_ALUOP_HI=7, CTRL_ALUOP_LO=6, CTRL_ALUSRC=5, CTRL_BRANCH=4, CTRL_MEMREAD=3, CTRL_MEMWRITE=2, CTRL_REGWRITE=1, CTRL_MEMTOREG=0).
  - CTRL_BUBBLE = 0.
  - Opcode constants shared with the decoder.
- One natural sub-module: hazard_detect. It is purely combinational and implements the hazard and srcRt equations; the register bank stays in id_ex_stage.

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0, outStall=0. Release, apply R-type control 9'b110000010 with inValid=1 -> next edge outControl=9'b110000010, outValid=1, data fields match inputs.
- Load-use on rs: EX holds load (control 9'b000101011, outRt=5); ID has R-type with inRs=5 -> outStall=1 same cycle; next edge outControl=0, outValid=0. Following edge the R-type is captured and outStall=0.
- Load-use on rt via store: EX load with outRt=7; ID store (9'b000100100) with inRt=7, inRs=3 -> stall. Same test with an immediate instruction (9'b011100010) and inRt=7 -> no stall, because srcRt=0.
- $zero exemption: EX load with outRt=0; ID R-type with inRs=0 -> outStall=0, instruction captured.
- Simultaneous flush and hazard: hazard conditions from the rs scenario plus inFlush=1 -> outStall=0, bubble inserted, outValid=0.
- With IDEX_STALL_CNT_EN and CNT_W=4: force 20 load-use bubbles -> outStallCount reads 15 and holds. 3 flush-only bubbles -> no change. Reset -> 0.
